// File: rtl/uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// uart_cmd_rx : 8N1 UART receiver and {"T":..,"L":..,"R":..} command decoder
// Revision    : 1.0
// ============================================================================

module uart_cmd_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int MAX_FRAME    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       uart_in,
  output logic [3:0] cmd_type,
  output logic [7:0] speed_l,
  output logic [7:0] speed_r,
  output logic       neg_l,
  output logic       neg_r,
  output logic       frame_valid,
  output logic       frame_error
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int LW = $clog2(MAX_FRAME + 1);
  localparam logic [CW-1:0] c_HALF   = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] c_FULL   = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] c_MAXLEN = LW'(MAX_FRAME);
  localparam logic [7:0] c_LBRACE = 8'h7B, c_RBRACE = 8'h7D, c_QUOTE = 8'h22;
  localparam logic [7:0] c_COLON  = 8'h3A, c_COMMA  = 8'h2C, c_MINUS = 8'h2D;
  localparam logic [7:0] c_DOT    = 8'h2E, c_NL     = 8'h0A;
  localparam logic [7:0] c_KEY_T  = 8'h54, c_KEY_L  = 8'h4C, c_KEY_R = 8'h52;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  typedef enum logic [3:0] {
    P_IDLE, P_KQ1, P_KEY, P_KQ2, P_COLON, P_SIGN_INT, P_INT,
    P_DOT_END, P_FRAC1, P_FRAC_REST, P_CLOSE_NL
  } p_state_t;

  logic            sync1_q, sync2_q;
  rx_state_t       rx_state_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            byte_stb_q, ferr_q;

  p_state_t        p_state_q;
  logic [2:0]      seen_q;     // {R, L, T}
  logic [1:0]      key_q;      // 0=T, 1=L, 2=R
  logic            neg_q;
  logic [3:0]      int_q, frac_q;
  logic [LW-1:0]   len_q;
  logic [3:0]      t_val_q;
  logic [7:0]      l_val_q, r_val_q;
  logic            l_neg_q, r_neg_q;

  logic            w_is_digit, w_sep, w_err;
  logic [2:0]      w_key_hit;
  logic [6:0]      w_mag;
  logic [7:0]      w_field_val;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= uart_in;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state_q <= RX_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      byte_stb_q <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      byte_stb_q <= 1'b0;
      ferr_q     <= 1'b0;
      unique case (rx_state_q)
        RX_IDLE: begin
          if (!sync2_q) begin
            rx_state_q <= RX_START;
            cnt_q      <= '0;
          end
        end
        RX_START: begin
          if (cnt_q == c_HALF) begin
            cnt_q      <= '0;
            bit_q      <= '0;
            rx_state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == c_FULL) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[7:1]};
            bit_q   <= bit_q + 1'b1;
            if (bit_q == 3'd7) rx_state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == c_FULL) begin
            byte_stb_q <= sync2_q;
            ferr_q     <= !sync2_q;
            rx_state_q <= RX_IDLE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // Byte legality for the current parser state; '{' and length are handled separately.
  always_comb begin
    w_is_digit  = (shift_q >= 8'h30) && (shift_q <= 8'h39);
    w_key_hit   = {shift_q == c_KEY_R, shift_q == c_KEY_L, shift_q == c_KEY_T};
    w_sep       = (shift_q == c_COMMA) || ((shift_q == c_RBRACE) && (&seen_q));
    w_mag       = 7'(int_q) * 7'd10 + 7'(frac_q);
    w_field_val = neg_q ? (8'd0 - {1'b0, w_mag}) : {1'b0, w_mag};
    w_err       = 1'b0;
    unique case (p_state_q)
      P_KQ1, P_KQ2:   w_err = (shift_q != c_QUOTE);
      P_KEY:          w_err = ~|(w_key_hit & ~seen_q);
      P_COLON:        w_err = (shift_q != c_COLON);
      P_SIGN_INT:     w_err = !(w_is_digit || ((shift_q == c_MINUS) && (key_q != 2'd0)));
      P_INT, P_FRAC1: w_err = !w_is_digit;
      P_DOT_END:      w_err = !((shift_q == c_DOT) || w_sep);
      P_FRAC_REST:    w_err = !(w_is_digit || w_sep);
      P_CLOSE_NL:     w_err = (shift_q != c_NL);
      default:        w_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      p_state_q   <= P_IDLE;
      seen_q      <= '0;
      key_q       <= '0;
      neg_q       <= 1'b0;
      int_q       <= '0;
      frac_q      <= '0;
      len_q       <= '0;
      t_val_q     <= '0;
      l_val_q     <= '0;
      r_val_q     <= '0;
      l_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      cmd_type    <= '0;
      speed_l     <= '0;
      speed_r     <= '0;
      neg_l       <= 1'b0;
      neg_r       <= 1'b0;
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_error <= 1'b0;
      if (ferr_q && (p_state_q != P_IDLE)) begin
        frame_error <= 1'b1;
        p_state_q   <= P_IDLE;
        seen_q      <= '0;
      end else if (byte_stb_q) begin
        if (shift_q == c_LBRACE) begin
          frame_error <= (p_state_q != P_IDLE);
          p_state_q   <= P_KQ1;
          seen_q      <= '0;
          len_q       <= LW'(1);
        end else if (p_state_q != P_IDLE) begin
          if ((len_q == c_MAXLEN) || w_err) begin
            frame_error <= 1'b1;
            p_state_q   <= P_IDLE;
            seen_q      <= '0;
          end else begin
            len_q <= len_q + 1'b1;
            unique case (p_state_q)
              P_KQ1: p_state_q <= P_KEY;
              P_KEY: begin
                key_q     <= {w_key_hit[2], w_key_hit[1]};
                seen_q    <= seen_q | w_key_hit;
                p_state_q <= P_KQ2;
              end
              P_KQ2: p_state_q <= P_COLON;
              P_COLON: begin
                neg_q     <= 1'b0;
                int_q     <= '0;
                frac_q    <= '0;
                p_state_q <= P_SIGN_INT;
              end
              P_SIGN_INT: begin
                if (shift_q == c_MINUS) begin
                  neg_q     <= 1'b1;
                  p_state_q <= P_INT;
                end else begin
                  int_q     <= shift_q[3:0];
                  p_state_q <= P_DOT_END;
                end
              end
              P_INT: begin
                int_q     <= shift_q[3:0];
                p_state_q <= P_DOT_END;
              end
              P_FRAC1: begin
                frac_q    <= shift_q[3:0];
                p_state_q <= P_FRAC_REST;
              end
              P_DOT_END, P_FRAC_REST: begin
                if (shift_q == c_DOT) begin
                  p_state_q <= P_FRAC1;
                end else if (!w_is_digit) begin
                  unique case (key_q)
                    2'd0:    t_val_q <= int_q;
                    2'd1:    begin l_val_q <= w_field_val; l_neg_q <= neg_q; end
                    default: begin r_val_q <= w_field_val; r_neg_q <= neg_q; end
                  endcase
                  p_state_q <= (shift_q == c_COMMA) ? P_KQ1 : P_CLOSE_NL;
                end
              end
              P_CLOSE_NL: begin
                cmd_type    <= t_val_q;
                speed_l     <= l_val_q;
                speed_r     <= r_val_q;
                neg_l       <= l_neg_q;
                neg_r       <= r_neg_q;
                frame_valid <= 1'b1;
                seen_q      <= '0;
                p_state_q   <= P_IDLE;
              end
              default: p_state_q <= P_IDLE;
            endcase
          end
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_rx.sv
`default_nettype none
// ============================================================================
// tb_uart_cmd_rx : directed frame table plus hand-built UART corner cases
// Revision       : 1.0
// ============================================================================

module tb_uart_cmd_rx;

  localparam int CPB  = 4;
  localparam int MAXF = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       uart_in;
  logic [3:0] cmd_type;
  logic [7:0] speed_l, speed_r;
  logic       neg_l, neg_r, frame_valid, frame_error;

  always #5 clk = ~clk;

  uart_cmd_rx #(.CLKS_PER_BIT(CPB), .MAX_FRAME(MAXF)) dut (
    .clk        (clk),
    .rst        (rst),
    .uart_in    (uart_in),
    .cmd_type   (cmd_type),
    .speed_l    (speed_l),
    .speed_r    (speed_r),
    .neg_l      (neg_l),
    .neg_r      (neg_r),
    .frame_valid(frame_valid),
    .frame_error(frame_error)
  );

  int checks = 0;
  int errors = 0;
  int nv = 0;
  int ne = 0;
  bit overlap = 1'b0;

  always @(negedge clk) begin
    if (frame_valid) nv++;
    if (frame_error) ne++;
    if (frame_valid && frame_error) overlap = 1'b1;
  end

  typedef struct {
    string      frame;
    int         nv;
    int         ne;
    logic [3:0] cmd;
    logic [7:0] sl;
    logic [7:0] sr;
    logic       nl;
    logic       nr;
  } vec_t;

  function automatic vec_t mk(string f, int v, int e, logic [3:0] c,
                              logic [7:0] l, logic [7:0] r, logic nl_e, logic nr_e);
    mk.frame = f; mk.nv = v; mk.ne = e; mk.cmd = c;
    mk.sl = l; mk.sr = r; mk.nl = nl_e; mk.nr = nr_e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] c, input logic [7:0] l,
                          input logic [7:0] r, input logic nl_e, input logic nr_e);
    chk({tag, "_cmd"}, 32'(cmd_type), 32'(c));
    chk({tag, "_sl"},  32'(speed_l),  32'(l));
    chk({tag, "_sr"},  32'(speed_r),  32'(r));
    chk({tag, "_nl"},  32'(neg_l),    32'(nl_e));
    chk({tag, "_nr"},  32'(neg_r),    32'(nr_e));
  endtask

  task automatic idle_bits(input int n);
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_in = 1'b0;
    idle_bits(1);
    for (int i = 0; i < 8; i++) begin
      uart_in = b[i];
      idle_bits(1);
    end
    uart_in = stop;
    idle_bits(1);
    uart_in = 1'b1;
    idle_bits(1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], 1'b1);
  endtask

  vec_t vecs[11];
  int   v0, e0;
  logic [7:0] partial;

  initial begin
    vecs[0]  = mk("{\"T\":1,\"L\":0.5,\"R\":0.5}\n",                  1, 0, 4'd1, 8'h05, 8'h05, 1'b0, 1'b0);
    vecs[1]  = mk("{\"T\":1,\"L\":-1.0,\"R\":0.25}\n",                1, 0, 4'd1, 8'hF6, 8'h02, 1'b1, 1'b0);
    vecs[2]  = mk("{\"R\":0.5,\"T\":2,\"L\":1}\n",                    1, 0, 4'd2, 8'h0A, 8'h05, 1'b0, 1'b0);
    vecs[3]  = mk("{\"L\":1,\"L\":1,\"R\":0}\n",                      0, 1, 4'd2, 8'h0A, 8'h05, 1'b0, 1'b0);
    vecs[4]  = mk("{\"T\":1,\"L\":0.5{\"T\":3,\"L\":-0.0,\"R\":-9.95}\n", 1, 1, 4'd3, 8'h00, 8'h9D, 1'b1, 1'b1);
    vecs[5]  = mk("{\"T\":1,\"L\":2}\n",                              0, 1, 4'd3, 8'h00, 8'h9D, 1'b1, 1'b1);
    vecs[6]  = mk("{\"T\":-1,\"L\":0,\"R\":0}\n",                     0, 1, 4'd3, 8'h00, 8'h9D, 1'b1, 1'b1);
    vecs[7]  = mk("{\"T\":7.9,\"L\":0,\"R\":-2}\n",                   1, 0, 4'd7, 8'h00, 8'hEC, 1'b0, 1'b1);
    // 32 bytes exactly (accepted), then 33 bytes (aborted on the newline)
    vecs[8]  = mk("{\"T\":1,\"L\":1.00000000000,\"R\":1}\n",          1, 0, 4'd1, 8'h0A, 8'h0A, 1'b0, 1'b0);
    vecs[9]  = mk("{\"T\":2,\"L\":1.000000000000,\"R\":1}\n",         0, 1, 4'd1, 8'h0A, 8'h0A, 1'b0, 1'b0);
    vecs[10] = mk("zz{\"T\":9,\"L\":9.9,\"R\":-0}\n",                 1, 0, 4'd9, 8'h63, 8'h00, 1'b0, 1'b1);

    rst     = 1'b1;
    uart_in = 1'b1;
    repeat (4) @(negedge clk);
    chk_outs("reset", 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("reset_valid", 32'(frame_valid), 32'd0);
    chk("reset_error", 32'(frame_error), 32'd0);
    rst = 1'b0;
    idle_bits(2);

    for (int i = 0; i < 11; i++) begin
      v0 = nv;
      e0 = ne;
      send_str(vecs[i].frame);
      idle_bits(1);
      chk($sformatf("v%0d_valid", i), 32'(nv - v0), 32'(vecs[i].nv));
      chk($sformatf("v%0d_error", i), 32'(ne - e0), 32'(vecs[i].ne));
      chk_outs($sformatf("v%0d", i), vecs[i].cmd, vecs[i].sl, vecs[i].sr, vecs[i].nl, vecs[i].nr);
    end

    // Low stop bit in the middle of an open frame
    v0 = nv;
    e0 = ne;
    send_str("{\"T\":4,\"L\":0.3");
    send_byte(8'h78, 1'b0);
    idle_bits(10);
    chk("ferr_valid", 32'(nv - v0), 32'd0);
    chk("ferr_error", 32'(ne - e0), 32'd1);
    chk_outs("ferr_hold", 4'd9, 8'h63, 8'h00, 1'b0, 1'b1);
    v0 = nv;
    e0 = ne;
    send_str("{\"T\":5,\"L\":0.1,\"R\":-0.1}\n");
    idle_bits(1);
    chk("after_ferr_valid", 32'(nv - v0), 32'd1);
    chk("after_ferr_error", 32'(ne - e0), 32'd0);
    chk_outs("after_ferr", 4'd5, 8'h01, 8'hFF, 1'b0, 1'b1);

    // Reset asserted during data bit 3 of a byte
    partial = 8'h41;
    uart_in = 1'b0;
    idle_bits(1);
    for (int i = 0; i < 3; i++) begin
      uart_in = partial[i];
      idle_bits(1);
    end
    uart_in = partial[3];
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    uart_in = 1'b1;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_outs("midrst", 4'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    idle_bits(4);
    v0 = nv;
    e0 = ne;
    send_str("{\"T\":8,\"L\":-0.7,\"R\":0.4}\n");
    idle_bits(1);
    chk("post_rst_valid", 32'(nv - v0), 32'd1);
    chk("post_rst_error", 32'(ne - e0), 32'd0);
    chk_outs("post_rst", 4'd8, 8'hF9, 8'h04, 1'b1, 1'b0);

    // One-cycle low glitch between bytes of an open frame must not create a byte
    v0 = nv;
    e0 = ne;
    send_str("{\"T\":6,\"L\":0.2,");
    uart_in = 1'b0;
    @(negedge clk);
    uart_in = 1'b1;
    idle_bits(3);
    send_str("\"R\":0.3}\n");
    idle_bits(1);
    chk("glitch_valid", 32'(nv - v0), 32'd1);
    chk("glitch_error", 32'(ne - e0), 32'd0);
    chk_outs("glitch", 4'd6, 8'h02, 8'h03, 1'b0, 1'b0);

    chk("no_overlap", 32'(overlap), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_cmd_rx.md
Name: uart_cmd_rx

Overview:
Serial receiver and JSON command decoder for the motor-control link. It deserialises 8N1 UART bytes from a GPIO pin and parses newline-terminated frames of the form {"T":1,"L":-0.5,"R":0.5}. On a well-formed frame it commits the command type and the signed left/right wheel speeds, which the motor blocks consume. It is the receive-side counterpart of the motor command transmitter and accepts exactly the frames that transmitter emits.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); minimum 4
MAX_FRAME, 32, maximum bytes from '{' to '\n' inclusive before the frame is aborted

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
uart_in  input  1  serial line, idle high, asynchronous to clk
cmd_type  output  4  integer part of the "T" value from the last good frame
speed_l  output  8  signed left speed in tenths (-99..99) from the last good frame
speed_r  output  8  signed right speed in tenths from the last good frame
neg_l  output  1  1 when the committed speed_l was sent with a '-' sign
neg_r  output  1  1 when the committed speed_r was sent with a '-' sign
frame_valid  output  1  one-cycle pulse when a new command is committed
frame_error  output  1  one-cycle pulse when a frame is aborted

Behaviour:
- Reset: all outputs 0, receiver in RX_IDLE, parser in P_IDLE, and all key-seen flags cleared. Reset overrides any in-flight byte.
- Input sync: uart_in passes through a 2-FF synchroniser whose flops reset to 1. All sampling uses the synchronised signal.
- Receiver FSM:
  - RX_IDLE -> RX_START on a low synchronised level.
  - RX_START: wait CLKS_PER_BIT/2 cycles. If the line is still low, go to RX_DATA; otherwise return to RX_IDLE as a glitch, with no error.
  - RX_DATA: sample 8 bits LSB first, one every CLKS_PER_BIT cycles.
  - RX_STOP: sample once more. A high stop bit produces a one-cycle internal byte strobe. A low stop bit is a framing error, then the FSM returns to RX_IDLE.
- Parser: consumes one byte per strobe. Expected sequence is '{' then three fields, then '}' then '\n'.
  - Field = '"' key '"' ':' value, with fields separated by ','.
  - Key is 'T', 'L' or 'R'. Keys may appear in any order.
  - Value = optional '-', exactly one digit, then an optional '.' followed by one or more digits.
  - Only the first fraction digit is kept; the remaining fraction digits are consumed and ignored.
- Parser states: P_IDLE, P_KQ1, P_KEY, P_KQ2, P_COLON, P_SIGN_INT, P_INT, P_DOT_END, P_FRAC1, P_FRAC_REST, P_CLOSE_NL.
  - In P_IDLE, any byte other than '{' is discarded silently.
- Value arithmetic: magnitude = int*10 + frac1, with frac1 = 0 if no '.'. The result is negated (two's complement, 8-bit) when '-' was seen. "-0.0" yields 0 with neg flag 1.
- "T" value: cmd_type = integer digit; its fraction is ignored. A '-' on T is an error.
- Commit: on '\n' in P_CLOSE_NL with all three keys seen exactly once:
  - cmd_type, speed_l, speed_r, neg_l and neg_r update on the same edge.
  - frame_valid pulses 1 cycle after the '\n' byte strobe.
  - The parser returns to P_IDLE.
  - Until a commit, the outputs hold their previous values.
- Errors: each produces one frame_error pulse, returns the parser to P_IDLE, clears the seen flags and leaves the outputs unchanged. Error causes:
  - unexpected character
  - unknown or duplicate key
  - missing key at '}'
  - more than MAX_FRAME bytes
  - UART framing error while a frame is open (a framing error in P_IDLE is silent)
- '{' received mid-frame: frame_error pulses and a new frame starts immediately with that '{' as its first byte.
- frame_valid and frame_error are never high in the same cycle.

Test Plan:
1. CLKS_PER_BIT=4; send {"T":1,"L":0.5,"R":0.5}\n -> one frame_valid pulse; cmd_type=1, speed_l=8'd5, speed_r=8'd5, neg_l=0, neg_r=0.
2. Send {"T":1,"L":-1.0,"R":0.25}\n -> speed_l=8'hF6, neg_l=1, speed_r=8'd2, neg_r=0.
3. Send {"R":0.5,"T":2,"L":1}\n -> valid; cmd_type=2, speed_l=10, speed_r=5. Then send {"L":1,"L":1,"R":0}\n -> frame_error pulse, outputs unchanged.
4. Send {"T":1,"L":0.5 followed immediately by a full good frame -> exactly one frame_error, then one frame_valid carrying the second frame's values.
5. Send a byte with a low stop bit mid-frame -> frame_error, no frame_valid. The next good frame is decoded correctly.
6. Assert rst during bit 3 of a byte -> all outputs 0. The following good frame decodes normally; a 1-cycle low glitch on uart_in produces no byte.
